// File: rtl/uart_row_sender.sv
// Host-side pixel-row UART transmitter: sends start/row/payload/end bytes,
// checks each acknowledge byte and reports a final status with a done pulse.
module uart_row_sender #(
  parameter int         DATA_BYTES            = 241,
  parameter logic [7:0] ANSWER_CODE_TAKE_ROW  = 8'hCC,
  parameter logic [7:0] ANSWER_CODE           = 8'hAA,
  parameter logic [7:0] END_WORD              = 8'hDD,
  parameter logic [7:0] SUCCESSFULLY_RECEIVED = 8'hBC,
  parameter logic [7:0] NOT_ALL_RECEIVED      = 8'h11,
  parameter int         TIMEOUT_CYCLES        = 1_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [8:0]              row,
  input  logic [8*DATA_BYTES-1:0] row_data,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    ok,
  output logic [1:0]              err_code
);

  localparam int IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DATA_BYTES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] ERR_BAD_ACK = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_REJECT  = 2'd3;

  typedef enum logic [3:0] {
    IDLE,
    SEND_START,
    ACK_START,
    SEND_ROW,
    ACK_ROW,
    SEND_DATA,
    ACK_DATA,
    SEND_END,
    WAIT_RESULT,
    FINISH
  } state_t;

  state_t           state;
  logic [7:0]       row_lo_q;
  logic [7:0]       payload_q [DATA_BYTES];
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             tx_guard;
  logic             send_state;
  logic             wait_state;
  logic             timed_out;
  logic [7:0]       ack_expect;

  // The guard blocks a strobe in the cycle right after the previous one,
  // before the UART has had a chance to raise tx_busy.
  assign send_state = state inside {SEND_START, SEND_ROW, SEND_DATA, SEND_END};
  assign wait_state = state inside {ACK_START, ACK_ROW, ACK_DATA, WAIT_RESULT};
  assign tx_start   = send_state && !tx_busy && !tx_guard;
  assign timed_out  = (wait_cnt == TIMEOUT_VAL);
  assign ack_expect = (state == ACK_DATA) ? ANSWER_CODE : ANSWER_CODE_TAKE_ROW;
  assign idx_next   = idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst_n && state == IDLE && start) begin
      for (int k = 0; k < DATA_BYTES; k++) begin
        payload_q[k] <= row_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      row_lo_q <= '0;
      idx      <= '0;
      wait_cnt <= '0;
      tx_guard <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ok       <= 1'b0;
      err_code <= '0;
    end else begin
      tx_guard <= tx_start;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            row_lo_q <= row[7:0];
            idx      <= '0;
            ok       <= 1'b0;
            err_code <= '0;
            busy     <= 1'b1;
            tx_data  <= {7'b0, row[8]};
            state    <= SEND_START;
          end
        end

        SEND_START, SEND_ROW, SEND_END: begin
          if (tx_start) begin
            wait_cnt <= '0;
            case (state)
              SEND_START: state <= ACK_START;
              SEND_ROW:   state <= ACK_ROW;
              default:    state <= WAIT_RESULT;
            endcase
          end
        end

        // The last payload byte is not acknowledged; END_WORD follows directly.
        SEND_DATA: begin
          if (tx_start) begin
            wait_cnt <= '0;
            if (idx == LAST_IDX) begin
              tx_data <= END_WORD;
              state   <= SEND_END;
            end else begin
              state <= ACK_DATA;
            end
          end
        end

        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          if (!wait_state) begin
            state <= IDLE;
          end else if (rx_valid) begin
            if (state == WAIT_RESULT) begin
              if (rx_data == SUCCESSFULLY_RECEIVED) ok <= 1'b1;
              else                                  err_code <= ERR_REJECT;
              done  <= 1'b1;
              state <= FINISH;
            end else if (rx_data != ack_expect) begin
              err_code <= ERR_BAD_ACK;
              done     <= 1'b1;
              state    <= FINISH;
            end else begin
              case (state)
                ACK_START: begin
                  tx_data <= row_lo_q;
                  state   <= SEND_ROW;
                end
                ACK_ROW: begin
                  tx_data <= payload_q[0];
                  state   <= SEND_DATA;
                end
                default: begin
                  idx     <= idx_next;
                  tx_data <= payload_q[idx_next];
                  state   <= SEND_DATA;
                end
              endcase
            end
          end else if (timed_out) begin
            err_code <= ERR_TIMEOUT;
            done     <= 1'b1;
            state    <= FINISH;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_row_sender.sv
// Randomized bench for uart_row_sender with a UART TX/RX responder and a
// protocol-level model of the byte stream and final status.
module tb_uart_row_sender;

  localparam int NB  = 4;
  localparam int TMO = 50;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [8:0]      row = '0;
  logic [8*NB-1:0] row_data = '0;
  logic [7:0]      tx_data;
  logic            tx_start;
  logic            tx_busy = 1'b0;
  logic [7:0]      rx_data = '0;
  logic            rx_valid = 1'b0;
  logic            busy, done, ok;
  logic [1:0]      err_code;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int reply_q[$];
  logic [7:0] cap_q[$];
  int cap_cyc_q[$];
  int reply_at = -1;
  int max_busy = 3;
  int rx_cyc = 0;
  int done_count = 0;
  int done_cyc = 0;
  logic last_ok = 1'b0;
  logic [1:0] last_err = '0;
  int proto_err = 0;
  logic prev_tx_start = 1'b0;

  uart_row_sender #(.DATA_BYTES(NB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .row(row), .row_data(row_data),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .done(done), .ok(ok), .err_code(err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      done_count++;
      done_cyc = cyc;
      last_ok  = ok;
      last_err = err_code;
    end
    if (tx_start && (tx_busy || prev_tx_start)) proto_err++;
    prev_tx_start = tx_start;
  end

  // UART pair: record each strobed byte, go busy a cycle later, then answer
  // with the next scripted reply (negative entries stay silent).
  initial begin : uart_emu
    int reply, c0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        cap_q.push_back(tx_data);
        cap_cyc_q.push_back(cyc);
        c0 = cyc;
        reply = (reply_q.size() > 0) ? reply_q.pop_front() : -1;
        @(posedge clk); #1 tx_busy = 1'b1;
        repeat ($urandom_range(max_busy, 1)) @(posedge clk);
        #1 tx_busy = 1'b0;
        if (reply >= 0) begin
          if (reply_at >= 0) begin
            while (cyc < c0 + reply_at) begin @(posedge clk); #1; end
          end else begin
            repeat ($urandom_range(4, 0)) begin @(posedge clk); #1; end
          end
          rx_data  = reply[7:0];
          rx_valid = 1'b1;
          rx_cyc   = cyc;
          @(posedge clk); #1 rx_valid = 1'b0;
        end
      end
    end
  end

  function automatic logic [7:0] exp_byte(input logic [8:0] r, input logic [31:0] pl, input int i);
    if (i == 0) return {7'b0, r[8]};
    if (i == 1) return r[7:0];
    if (i < 6)  return pl[8*(i-2) +: 8];
    return 8'hDD;
  endfunction

  // Protocol walk: 7 bytes go out; every byte but the last payload byte
  // expects an answer, and the first bad or missing answer ends the row.
  task automatic model(input int scr[7], output int n_sent, output logic eok, output logic [1:0] eerr);
    n_sent = 0; eok = 1'b0; eerr = 2'd0;
    for (int i = 0; i < 7; i++) begin
      n_sent = i + 1;
      if (i == 5) continue;
      if (scr[i] < 0) begin eerr = 2'd2; return; end
      if (i == 6) begin
        if (scr[i] == 8'hBC) eok = 1'b1; else eerr = 2'd3;
        return;
      end
      if (scr[i] != ((i < 2) ? 8'hCC : 8'hAA)) begin eerr = 2'd1; return; end
    end
  endtask

  task automatic do_transfer(input logic [8:0] r, input logic [31:0] pl, input int scr[7],
                             input int dup_at, output logic to);
    int d0;
    reply_q.delete(); cap_q.delete(); cap_cyc_q.delete();
    foreach (scr[i]) reply_q.push_back(scr[i]);
    d0 = done_count;
    @(posedge clk); #1; start = 1'b1; row = r; row_data = pl;
    @(posedge clk); #1; start = 1'b0; row = 9'($urandom); row_data = $urandom;
    to = 1'b1;
    for (int k = 1; k < 4000; k++) begin
      if (done_count != d0) begin to = 1'b0; break; end
      start = (k == dup_at);
      if (k == dup_at) row = ~r;
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; row = 9'h1FF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_start: got %b want 0", tx_start); end
    vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_tx_data: got %h want 00", tx_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    vectors++; if (ok !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ok: got %b want 0", ok); end
    vectors++; if (err_code !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_err: got %0d want 0", err_code); end
    @(posedge clk); #1; start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_normal();
    logic [8:0] r; logic [31:0] pl; int scr[7]; int n; logic eok; logic [1:0] eerr; logic to; int d0;
    scr = '{8'hCC, 8'hCC, 8'hAA, 8'hAA, 8'hAA, -1, 8'hBC};
    for (int it = 0; it < 5; it++) begin
      if (it == 0) begin r = 9'h105; pl = 32'h44332211; max_busy = 1; end
      else begin r = 9'($urandom); pl = $urandom; max_busy = $urandom_range(5, 1); end
      model(scr, n, eok, eerr);
      d0 = done_count;
      do_transfer(r, pl, scr, 0, to);
      vectors++; if (to) begin miscompares++; $display("[TB] FAIL normal_done_wait: no done within bound (it %0d)", it); end
      vectors++; if (done_count - d0 != 1) begin miscompares++; $display("[TB] FAIL normal_done_count: got %0d want 1", done_count - d0); end
      vectors++; if (cap_q.size() != n) begin miscompares++; $display("[TB] FAIL normal_tx_count: got %0d want %0d", cap_q.size(), n); end
      for (int i = 0; i < n && i < cap_q.size(); i++) begin
        vectors++;
        if (cap_q[i] !== exp_byte(r, pl, i)) begin miscompares++; $display("[TB] FAIL normal_tx_byte%0d: got %h want %h", i, cap_q[i], exp_byte(r, pl, i)); end
      end
      vectors++; if (last_ok !== eok) begin miscompares++; $display("[TB] FAIL normal_ok: got %b want %b", last_ok, eok); end
      vectors++; if (last_err !== eerr) begin miscompares++; $display("[TB] FAIL normal_err: got %0d want %0d", last_err, eerr); end
      vectors++; if (ok !== eok) begin miscompares++; $display("[TB] FAIL normal_ok_hold: got %b want %b", ok, eok); end
    end
    vectors++; if (proto_err != 0) begin miscompares++; $display("[TB] FAIL send_rule: got %0d violations want 0", proto_err); end
  endtask

  task automatic test_reject();
    logic [8:0] r; logic [31:0] pl; int scr[7]; int n; logic eok; logic [1:0] eerr; logic to;
    for (int it = 0; it < 3; it++) begin
      r = 9'($urandom); pl = $urandom;
      scr = '{8'hCC, 8'hCC, 8'hAA, 8'hAA, 8'hAA, -1, 8'h11};
      if (it > 0) scr[6] = 8'hBC ^ $urandom_range(255, 1);
      model(scr, n, eok, eerr);
      do_transfer(r, pl, scr, 0, to);
      vectors++; if (to) begin miscompares++; $display("[TB] FAIL reject_done_wait: no done within bound"); end
      vectors++; if (cap_q.size() != n) begin miscompares++; $display("[TB] FAIL reject_tx_count: got %0d want %0d", cap_q.size(), n); end
      for (int i = 0; i < n && i < cap_q.size(); i++) begin
        vectors++;
        if (cap_q[i] !== exp_byte(r, pl, i)) begin miscompares++; $display("[TB] FAIL reject_tx_byte%0d: got %h want %h", i, cap_q[i], exp_byte(r, pl, i)); end
      end
      vectors++; if (last_ok !== eok) begin miscompares++; $display("[TB] FAIL reject_ok: got %b want %b", last_ok, eok); end
      vectors++; if (last_err !== eerr) begin miscompares++; $display("[TB] FAIL reject_err: got %0d want %0d", last_err, eerr); end
    end
  endtask

  task automatic test_wrong_ack();
    logic [8:0] r; logic [31:0] pl; int scr[7]; int n; logic eok; logic [1:0] eerr; logic to; int pos;
    for (int it = 0; it < 4; it++) begin
      r = 9'($urandom); pl = $urandom;
      scr = '{8'hCC, 8'hCC, 8'hAA, 8'hAA, 8'hAA, -1, 8'hBC};
      if (it == 0) begin pos = 1; scr[1] = 8'hAB; end
      else begin pos = $urandom_range(4, 0); scr[pos] = scr[pos] ^ $urandom_range(255, 1); end
      model(scr, n, eok, eerr);
      do_transfer(r, pl, scr, 0, to);
      vectors++; if (to) begin miscompares++; $display("[TB] FAIL wrong_ack_done_wait: no done within bound"); end
      vectors++; if (cap_q.size() != n) begin miscompares++; $display("[TB] FAIL wrong_ack_tx_count: got %0d want %0d (pos %0d)", cap_q.size(), n, pos); end
      vectors++; if (last_err !== eerr) begin miscompares++; $display("[TB] FAIL wrong_ack_err: got %0d want %0d", last_err, eerr); end
      vectors++; if (last_ok !== eok) begin miscompares++; $display("[TB] FAIL wrong_ack_ok: got %b want %b", last_ok, eok); end
      vectors++; if (done_cyc - rx_cyc != 1) begin miscompares++; $display("[TB] FAIL wrong_ack_latency: got %0d want 1", done_cyc - rx_cyc); end
    end
  endtask

  task automatic test_timeout();
    logic [8:0] r; logic [31:0] pl; int scr[7]; int n; logic eok; logic [1:0] eerr; logic to; int lat;
    r = 9'($urandom); pl = $urandom;
    scr = '{-1, 8'hCC, 8'hAA, 8'hAA, 8'hAA, -1, 8'hBC};
    model(scr, n, eok, eerr);
    do_transfer(r, pl, scr, 0, to);
    lat = (cap_cyc_q.size() > 0) ? done_cyc - cap_cyc_q[0] : -1;
    vectors++; if (to) begin miscompares++; $display("[TB] FAIL timeout_done_wait: no done within bound"); end
    vectors++; if (last_err !== eerr) begin miscompares++; $display("[TB] FAIL timeout_err: got %0d want %0d", last_err, eerr); end
    vectors++; if (cap_q.size() != n) begin miscompares++; $display("[TB] FAIL timeout_tx_count: got %0d want %0d", cap_q.size(), n); end
    vectors++; if (lat != TMO + 2) begin miscompares++; $display("[TB] FAIL timeout_latency: got %0d want %0d", lat, TMO + 2); end
    // Answers landing on the last counted cycle still count; one later does not.
    for (int it = 0; it < 2; it++) begin
      reply_at = TMO + 1 + it;
      scr = '{8'hCC, 8'hCC, 8'hAA, 8'hAA, 8'hAA, -1, 8'hBC};
      n = (it == 0) ? 7 : 1;
      eok = (it == 0);
      eerr = (it == 0) ? 2'd0 : 2'd2;
      do_transfer(r, pl, scr, 0, to);
      vectors++; if (to) begin miscompares++; $display("[TB] FAIL timeout_edge_wait: no done within bound (it %0d)", it); end
      vectors++; if (last_err !== eerr) begin miscompares++; $display("[TB] FAIL timeout_edge_err: got %0d want %0d", last_err, eerr); end
      vectors++; if (last_ok !== eok) begin miscompares++; $display("[TB] FAIL timeout_edge_ok: got %b want %b", last_ok, eok); end
      vectors++; if (cap_q.size() != n) begin miscompares++; $display("[TB] FAIL timeout_edge_tx_count: got %0d want %0d", cap_q.size(), n); end
    end
    reply_at = -1;
  endtask

  task automatic test_reset_mid();
    logic [8:0] r; logic [31:0] pl; int scr[7]; logic to; logic hit; int d0;
    r = 9'($urandom); pl = $urandom;
    scr = '{8'hCC, 8'hCC, 8'hAA, 8'hAA, 8'hAA, -1, 8'hBC};
    reply_q.delete(); cap_q.delete(); cap_cyc_q.delete();
    foreach (scr[i]) reply_q.push_back(scr[i]);
    @(posedge clk); #1; start = 1'b1; row = r; row_data = pl;
    @(posedge clk); #1; start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (cap_q.size() >= 3) begin hit = 1'b1; break; end
      @(posedge clk); #1;
    end
    vectors++; if (!hit) begin miscompares++; $display("[TB] FAIL reset_mid_reach: first payload byte never sent"); end
    d0 = done_count;
    rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mid_busy: got %b want 0", busy); end
    vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mid_tx_start: got %b want 0", tx_start); end
    vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_mid_tx_data: got %h want 00", tx_data); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mid_done: got %b want 0", done); end
    vectors++; if (err_code !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_mid_err: got %0d want 0", err_code); end
    repeat (40) @(posedge clk);
    #1;
    vectors++; if (done_count != d0) begin miscompares++; $display("[TB] FAIL reset_mid_no_done: got %0d pulses want 0", done_count - d0); end
    r = 9'($urandom); pl = $urandom;
    do_transfer(r, pl, scr, 0, to);
    vectors++; if (to) begin miscompares++; $display("[TB] FAIL reset_mid_fresh_wait: no done within bound"); end
    vectors++; if (last_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_mid_fresh_ok: got %b want 1", last_ok); end
    vectors++; if (cap_q.size() != 7) begin miscompares++; $display("[TB] FAIL reset_mid_fresh_count: got %0d want 7", cap_q.size()); end
    for (int i = 0; i < 7 && i < cap_q.size(); i++) begin
      vectors++;
      if (cap_q[i] !== exp_byte(r, pl, i)) begin miscompares++; $display("[TB] FAIL reset_mid_fresh_byte%0d: got %h want %h", i, cap_q[i], exp_byte(r, pl, i)); end
    end
  endtask

  task automatic test_start_while_busy();
    logic [8:0] r; logic [31:0] pl; int scr[7]; logic to; int d0;
    r = 9'($urandom); pl = $urandom;
    scr = '{8'hCC, 8'hCC, 8'hAA, 8'hAA, 8'hAA, -1, 8'hBC};
    d0 = done_count;
    do_transfer(r, pl, scr, 6, to);
    vectors++; if (to) begin miscompares++; $display("[TB] FAIL busy_start_wait: no done within bound"); end
    vectors++; if (done_count - d0 != 1) begin miscompares++; $display("[TB] FAIL busy_start_done_count: got %0d want 1", done_count - d0); end
    vectors++; if (cap_q.size() != 7) begin miscompares++; $display("[TB] FAIL busy_start_tx_count: got %0d want 7", cap_q.size()); end
    for (int i = 0; i < 7 && i < cap_q.size(); i++) begin
      vectors++;
      if (cap_q[i] !== exp_byte(r, pl, i)) begin miscompares++; $display("[TB] FAIL busy_start_byte%0d: got %h want %h", i, cap_q[i], exp_byte(r, pl, i)); end
    end
    vectors++; if (last_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_start_ok: got %b want 1", last_ok); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_start_idle: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_reject();
    test_wrong_ack();
    test_timeout();
    test_reset_mid();
    test_start_while_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
